reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
Architectural register file with ROB-tag renaming. It sits directly downstream of the reorder buffer's commit port and beside the issue stage.
- Issue stage: claims a destination register by recording the ROB tag of the producing instruction, and reads operands as either a committed value or a pending tag.
- ROB commit: retires values into the file and releases tags; ROB rollback flushes all pending renames.

Parameters:
TAG_W, 4, ROB tag width (ROB size = 2**TAG_W)
XLEN, 32, register data width

Ports:
clk  in  1  clock
rst  in  1  reset
rdy  in  1  global ready; state holds when low
issue_valid  in  1  instruction issued this cycle
issue_rd  in  5  destination register of issued instruction
issue_tag  in  TAG_W  ROB tag allocated to issued instruction (ROB next tag)
rs1  in  5  operand-1 index
rs2  in  5  operand-2 index
rs1_busy  out  1  operand 1 pending (value not yet committed)
rs1_tag  out  TAG_W  ROB tag producing operand 1 (valid when rs1_busy)
rs1_val  out  XLEN  operand-1 value (valid when !rs1_busy)
rs2_busy  out  1  as rs1
rs2_tag  out  TAG_W  as rs1
rs2_val  out  XLEN  as rs1
commit_valid  in  1  ROB commit strobe
commit_rd  in  5  committed destination
commit_rdTag  in  TAG_W  ROB tag of committed entry
commit_rdVal  in  XLEN  committed value
rollback  in  1  misprediction flush from ROB

Behaviour:
- Reset: clk is the clock; rst is a synchronous, active-high reset.
  - On rst, every value, busy bit and tag is cleared to 0.
  - Read outputs are combinational from state, so after reset they are busy=0, tag=0, val=0.
- State: val[32], busy[32], tag[32]. x0 is hard-wired: val=0 and busy=0 always. Writes and claims targeting x0 are ignored.
- rdy=0: no state update. Read ports stay combinational.
- Read ports (combinational, zero latency), evaluated per port:
  - Index 0 -> busy=0, val=0.
  - Commit bypass: if commit_valid && commit_rd==rs && rs!=0 && busy[rs] && tag[rs]==commit_rdTag -> busy=0, val=commit_rdVal.
  - Otherwise -> busy[rs], tag[rs], val[rs].
  - Reads see pre-issue state. An instruction reading and writing the same register in its issue cycle (add x1,x1,x2) gets the old mapping.
- Commit (posedge, rdy, commit_valid, commit_rd!=0):
  - val[commit_rd] <= commit_rdVal, unconditionally (in-order commit).
  - busy[commit_rd] <= 0 only if tag[commit_rd]==commit_rdTag and there is no same-cycle issue claim of commit_rd.
  - Tag mismatch means a younger writer owns the register: the value is written and busy/tag are untouched.
- Issue (posedge, rdy, issue_valid, issue_rd!=0, !rollback): busy[issue_rd] <= 1, tag[issue_rd] <= issue_tag.
  - Issue takes priority over the busy-clear of a same-cycle commit to the same register.
- Rollback (posedge, rdy, rollback=1):
  - All busy <= 0.
  - A same-cycle issue claim is dropped.
  - A same-cycle commit value write still takes effect.
  - Tags are left stale; they are don't-care while busy=0.
- Rollback and rst both take one cycle. The first read after either returns no busy registers.
- Tag wrap-around: tags are reused modulo 2**TAG_W. Correctness relies on the ROB never holding two live entries with the same tag, which the ROB's full logic guarantees. The equality compare needs no age logic.

Decomposition:
- The shared defines file holds the tag range, ROB size, register count (32) and True/False constants, alongside the existing ROB definitions.
- One natural sub-module, reg_read_port: the combinational x0/bypass/lookup mux, instantiated twice (rs1, rs2).
- All sequential state stays in reg_file.

Test Plan:
1. rst, then read rs1=5, rs2=0 -> busy=0, val=0 on both.
2. Issue rd=3 tag=7; next cycle read rs1=3 -> busy=1, tag=7. Commit rd=3 tag=7 val=0xDEADBEEF -> same-cycle read shows busy=0, val=0xDEADBEEF; next cycle the stored value holds it.
3. Issue rd=4 tag=2, then issue rd=4 tag=5, then commit rd=4 tag=2 val=0x11 -> val[4]=0x11, busy=1, tag=5. Commit tag=5 val=0x22 -> busy=0, val=0x22.
4. Same cycle: commit rd=6 tag=1 (owner) and issue rd=6 tag=9 -> val[6]=commit value, busy=1, tag=9.
5. Issue rd=1,2,3 (tags 1,2,3), then rollback with a same-cycle issue rd=8 tag=4 -> busy all 0 including x8; prior values unchanged.
6. Issue rd=0 and commit rd=0 val=0xFFFF; also hold rdy=0 during an issue -> x0 reads 0, not busy; no state change while rdy=0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared register-file and ROB tag definitions
package reg_file_pkg;

    localparam int ROB_TAG_W = 4;
    localparam int ROB_SIZE  = 1 << ROB_TAG_W;
    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_read_port.sv
// rtl/reg_read_port.sv - one operand read port: x0 force, commit bypass, file lookup
module reg_read_port
    import reg_file_pkg::*;
#(
    parameter int TAG_W = ROB_TAG_W,
    parameter int XLEN  = 32
) (
    input  reg_idx_t          rs_i,
    input  logic              busy_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [XLEN-1:0]   val_i,
    input  logic              commit_valid_i,
    input  reg_idx_t          commit_rd_i,
    input  logic [TAG_W-1:0]  commit_tag_i,
    input  logic [XLEN-1:0]   commit_val_i,
    output logic              busy_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [XLEN-1:0]   val_o
);

    logic bypass;

    // Forward only when the committing entry is the register's current owner.
    assign bypass = commit_valid_i && (commit_rd_i == rs_i) && (rs_i != '0)
                    && busy_i && (tag_i == commit_tag_i);

    always_comb begin
        busy_o = busy_i;
        tag_o  = tag_i;
        val_o  = val_i;
        if (rs_i == '0) begin
            busy_o = FALSE;
            val_o  = '0;
        end else if (bypass) begin
            busy_o = FALSE;
            val_o  = commit_val_i;
        end
    end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - architectural register file with ROB-tag renaming
module reg_file
    import reg_file_pkg::*;
#(
    parameter int TAG_W = ROB_TAG_W,
    parameter int XLEN  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              issue_valid,
    input  logic [4:0]        issue_rd,
    input  logic [TAG_W-1:0]  issue_tag,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    output logic              rs1_busy,
    output logic [TAG_W-1:0]  rs1_tag,
    output logic [XLEN-1:0]   rs1_val,
    output logic              rs2_busy,
    output logic [TAG_W-1:0]  rs2_tag,
    output logic [XLEN-1:0]   rs2_val,
    input  logic              commit_valid,
    input  logic [4:0]        commit_rd,
    input  logic [TAG_W-1:0]  commit_rdTag,
    input  logic [XLEN-1:0]   commit_rdVal,
    input  logic              rollback
);

    logic [XLEN-1:0]  val_q  [NUM_REGS];
    logic [XLEN-1:0]  val_d  [NUM_REGS];
    logic [TAG_W-1:0] tag_q  [NUM_REGS];
    logic [TAG_W-1:0] tag_d  [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (rdy) begin
            // Values always land (in-order commit); ownership decides the busy clear.
            if (commit_valid && commit_rd != '0) begin
                val_d[commit_rd] = commit_rdVal;
                if (tag_q[commit_rd] == commit_rdTag) begin
                    busy_d[commit_rd] = FALSE;
                end
            end
            if (issue_valid && issue_rd != '0 && !rollback) begin
                busy_d[issue_rd] = TRUE;
                tag_d[issue_rd]  = issue_tag;
            end
            if (rollback) begin
                busy_d = '0;
            end
        end
        val_d[0]  = '0;
        busy_d[0] = FALSE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            val_q  <= val_d;
            tag_q  <= tag_d;
        end
    end

    reg_read_port #(.TAG_W(TAG_W), .XLEN(XLEN)) u_rd1 (
        .rs_i           (rs1),
        .busy_i         (busy_q[rs1]),
        .tag_i          (tag_q[rs1]),
        .val_i          (val_q[rs1]),
        .commit_valid_i (commit_valid),
        .commit_rd_i    (commit_rd),
        .commit_tag_i   (commit_rdTag),
        .commit_val_i   (commit_rdVal),
        .busy_o         (rs1_busy),
        .tag_o          (rs1_tag),
        .val_o          (rs1_val)
    );

    reg_read_port #(.TAG_W(TAG_W), .XLEN(XLEN)) u_rd2 (
        .rs_i           (rs2),
        .busy_i         (busy_q[rs2]),
        .tag_i          (tag_q[rs2]),
        .val_i          (val_q[rs2]),
        .commit_valid_i (commit_valid),
        .commit_rd_i    (commit_rd),
        .commit_tag_i   (commit_rdTag),
        .commit_val_i   (commit_rdVal),
        .busy_o         (rs2_busy),
        .tag_o          (rs2_tag),
        .val_o          (rs2_val)
    );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file
module tb_reg_file;

    localparam int TAG_W = 4;
    localparam int XLEN  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic              issue_valid;
    logic [4:0]        issue_rd;
    logic [TAG_W-1:0]  issue_tag;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              rs1_busy;
    logic [TAG_W-1:0]  rs1_tag;
    logic [XLEN-1:0]   rs1_val;
    logic              rs2_busy;
    logic [TAG_W-1:0]  rs2_tag;
    logic [XLEN-1:0]   rs2_val;
    logic              commit_valid;
    logic [4:0]        commit_rd;
    logic [TAG_W-1:0]  commit_rdTag;
    logic [XLEN-1:0]   commit_rdVal;
    logic              rollback;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_file #(.TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_tag    (issue_tag),
        .rs1          (rs1),
        .rs2          (rs2),
        .rs1_busy     (rs1_busy),
        .rs1_tag      (rs1_tag),
        .rs1_val      (rs1_val),
        .rs2_busy     (rs2_busy),
        .rs2_tag      (rs2_tag),
        .rs2_val      (rs2_val),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_rdTag (commit_rdTag),
        .commit_rdVal (commit_rdVal),
        .rollback     (rollback)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
        rollback     = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [TAG_W-1:0] t);
        issue_valid = 1'b1;
        issue_rd    = rd;
        issue_tag   = t;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
        commit_valid = 1'b1;
        commit_rd    = rd;
        commit_rdTag = t;
        commit_rdVal = v;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1;
        issue_rd = '0; issue_tag = '0; commit_rd = '0; commit_rdTag = '0; commit_rdVal = '0;
        rs1 = '0; rs2 = '0;
        idle();
        step();
        rst = 1'b0;

        // reset state
        rs1 = 5; rs2 = 0; #1;
        check("rst_rs1_busy", 32'(rs1_busy), 0);
        check("rst_rs1_val",  rs1_val, 0);
        check("rst_rs2_busy", 32'(rs2_busy), 0);
        check("rst_rs2_val",  rs2_val, 0);

        // issue then owner commit with bypass
        issue(3, 7); step(); idle();
        rs1 = 3; #1;
        check("t2_busy", 32'(rs1_busy), 1);
        check("t2_tag",  32'(rs1_tag), 7);
        commit(3, 7, 32'hDEADBEEF); #1;
        check("t2_byp_busy", 32'(rs1_busy), 0);
        check("t2_byp_val",  rs1_val, 32'hDEADBEEF);
        step(); idle(); #1;
        check("t2_st_busy", 32'(rs1_busy), 0);
        check("t2_st_val",  rs1_val, 32'hDEADBEEF);

        // stale commit from older writer
        issue(4, 2); step();
        issue(4, 5); step(); idle();
        rs1 = 4;
        commit(4, 2, 32'h11); #1;
        check("t3_nobyp_busy", 32'(rs1_busy), 1);
        check("t3_nobyp_tag",  32'(rs1_tag), 5);
        step(); idle(); #1;
        check("t3_old_busy", 32'(rs1_busy), 1);
        check("t3_old_tag",  32'(rs1_tag), 5);
        check("t3_old_val",  rs1_val, 32'h11);
        commit(4, 5, 32'h22); #1;
        check("t3_byp_val", rs1_val, 32'h22);
        step(); idle(); #1;
        check("t3_new_busy", 32'(rs1_busy), 0);
        check("t3_new_val",  rs1_val, 32'h22);

        // same-cycle commit and issue to one register
        issue(6, 1); step(); idle();
        commit(6, 1, 32'h66); issue(6, 9); step(); idle();
        rs2 = 6; #1;
        check("t4_busy", 32'(rs2_busy), 1);
        check("t4_tag",  32'(rs2_tag), 9);
        check("t4_val",  rs2_val, 32'h66);

        // rollback drops pending renames and same-cycle claim
        issue(1, 1); step();
        issue(2, 2); step();
        issue(3, 3); step(); idle();
        rs1 = 2; #1;
        check("t5_pre_busy", 32'(rs1_busy), 1);
        rollback = 1'b1; issue(8, 4); commit(5, 0, 32'h55); step(); idle();
        for (int r = 1; r <= 8; r++) begin
            rs1 = 5'(r); #1;
            check($sformatf("t5_busy_x%0d", r), 32'(rs1_busy), 0);
        end
        rs1 = 3; rs2 = 5; #1;
        check("t5_val_x3", rs1_val, 32'hDEADBEEF);
        check("t5_val_x5", rs2_val, 32'h55);

        // x0 writes ignored
        issue(0, 3); commit(0, 3, 32'hFFFF); rs1 = 0; step(); idle(); #1;
        check("t6_x0_busy", 32'(rs1_busy), 0);
        check("t6_x0_val",  rs1_val, 0);

        // rdy low holds state
        rdy = 1'b0; issue(9, 6); commit(3, 3, 32'h1234); rs1 = 3; #1;
        check("t6_rdy_read", rs1_val, 32'hDEADBEEF);
        step(); idle(); rdy = 1'b1;
        rs1 = 9; rs2 = 3; #1;
        check("t6_hold_busy", 32'(rs1_busy), 0);
        check("t6_hold_val",  rs2_val, 32'hDEADBEEF);

        // reset clears populated state
        issue(7, 15); step(); idle();
        rst = 1'b1; step(); rst = 1'b0;
        rs1 = 3; rs2 = 7; #1;
        check("rst2_val_x3",  rs1_val, 0);
        check("rst2_busy_x7", 32'(rs2_busy), 0);
        check("rst2_tag_x7",  32'(rs2_tag), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
